// File: rtl/branch_pattern_predictor_pkg.sv
// Shared types for the pattern history table: 2-bit counter type, clear value,
// controller states and the saturating counter step.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_WNT = 2'b01;

  typedef enum logic {BP_IDLE, BP_CLEAR} bp_state_t;

  function automatic ctr_t sat_next(ctr_t c, logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_pattern_predictor_pht_row.sv
// One PHT row: 2**HIST_WIDTH saturating counters with a training write port,
// a clear port and two combinational read ports (prediction and update).
module pht_row
  import bp_pkg::*;
#(
  parameter int   HIST_WIDTH = 3,
  parameter ctr_t CTR_INIT   = CTR_WNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [HIST_WIDTH-1:0] widx_i,
  input  ctr_t                  wdata_i,
  input  logic                  clr_i,
  input  logic [HIST_WIDTH-1:0] cidx_i,
  input  logic [HIST_WIDTH-1:0] ridx_a_i,
  output ctr_t                  rdata_a_o,
  input  logic [HIST_WIDTH-1:0] ridx_b_i,
  output ctr_t                  rdata_b_o
);

  localparam int N = 1 << HIST_WIDTH;

  ctr_t ctr_q [N];

  // Clear wins over training; the controller never issues both to one row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= CTR_INIT;
    end else if (clr_i) begin
      ctr_q[cidx_i] <= CTR_INIT;
    end else if (we_i) begin
      ctr_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_a_o = ctr_q[ridx_a_i];
  assign rdata_b_o = ctr_q[ridx_b_i];

endmodule

// File: rtl/branch_pattern_predictor.sv
// Pattern history table behind the branch history cache: zero-latency prediction,
// one-cycle registered training with forwarding, and an 8-cycle row clear on evict.
module branch_pattern_predictor
  import bp_pkg::*;
#(
  parameter int   ROW_WIDTH  = 4,
  parameter int   HIST_WIDTH = 3,
  parameter ctr_t CTR_INIT   = CTR_WNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            pc,
  input  logic [HIST_WIDTH-1:0] read_history,
  input  logic                  read_hit,
  output logic                  predict_taken,
  output logic                  predict_valid,
  input  logic                  upd_valid,
  input  logic [9:0]            upd_pc,
  input  logic [HIST_WIDTH-1:0] upd_history,
  input  logic                  upd_taken,
  input  logic                  evict,
  output logic                  upd_ready,
  output logic                  busy
);

  localparam int ROWS = 1 << ROW_WIDTH;
  localparam logic [HIST_WIDTH-1:0] LAST_IDX = '1;

  bp_state_t             state_q, state_d;
  logic [HIST_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [ROW_WIDTH-1:0]  clr_row_q, clr_row_d;
  logic                  u_v_q, u_v_d;
  logic [ROW_WIDTH-1:0]  u_row_q, u_row_d;
  logic [HIST_WIDTH-1:0] u_hist_q, u_hist_d;
  logic                  u_taken_q, u_taken_d;

  ctr_t                  rd_a [ROWS];
  ctr_t                  rd_b [ROWS];
  logic [ROW_WIDTH-1:0]  rd_row, upd_row;
  logic                  clearing, accept, fwd_hit;
  ctr_t                  u_new, c_sel;
  logic                  unused_pc_hi;

  assign rd_row       = pc[ROW_WIDTH-1:0];
  assign upd_row      = upd_pc[ROW_WIDTH-1:0];
  assign unused_pc_hi = ^{pc[9:ROW_WIDTH], upd_pc[9:ROW_WIDTH]};

  assign clearing  = (state_q == BP_CLEAR);
  assign busy      = clearing;
  assign upd_ready = ~clearing;
  assign accept    = upd_valid & upd_ready;

  // The pending update is applied against the live array value at commit time,
  // so a following update to the same slot sees the committed result.
  assign u_new   = sat_next(rd_b[u_row_q], u_taken_q);
  assign fwd_hit = u_v_q && (u_row_q == rd_row) && (u_hist_q == read_history);
  assign c_sel   = fwd_hit ? u_new : rd_a[rd_row];

  assign predict_valid = read_hit & ~clearing;
  assign predict_taken = predict_valid & c_sel[1];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    pht_row #(
      .HIST_WIDTH (HIST_WIDTH),
      .CTR_INIT   (CTR_INIT)
    ) u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (u_v_q && (u_row_q == ROW_WIDTH'(r))),
      .widx_i    (u_hist_q),
      .wdata_i   (u_new),
      .clr_i     (clearing && (clr_row_q == ROW_WIDTH'(r))),
      .cidx_i    (clr_idx_q),
      .ridx_a_i  (read_history),
      .rdata_a_o (rd_a[r]),
      .ridx_b_i  (u_hist_q),
      .rdata_b_o (rd_b[r])
    );
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_row_d = clr_row_q;
    u_v_d     = 1'b0;
    u_row_d   = u_row_q;
    u_hist_d  = u_hist_q;
    u_taken_d = u_taken_q;
    unique case (state_q)
      BP_IDLE: begin
        if (accept) begin
          if (evict) begin
            state_d   = BP_CLEAR;
            clr_row_d = upd_row;
            clr_idx_d = '0;
          end else begin
            u_v_d     = 1'b1;
            u_row_d   = upd_row;
            u_hist_d  = upd_history;
            u_taken_d = upd_taken;
          end
        end
      end
      BP_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) state_d = BP_IDLE;
      end
      default: state_d = BP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BP_IDLE;
      clr_idx_q <= '0;
      u_v_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      u_v_q     <= u_v_d;
    end
  end

  // Payload registers are only consumed when qualified by state or u_v_q.
  always_ff @(posedge clk) begin
    clr_row_q <= clr_row_d;
    u_row_q   <= u_row_d;
    u_hist_q  <= u_hist_d;
    u_taken_q <= u_taken_d;
  end

endmodule

// File: tb/tb_branch_pattern_predictor.sv
// Scoreboard bench for branch_pattern_predictor: expected {valid,taken} pairs are
// queued from a reference counter table when reads are driven and popped at negedge.
module tb_branch_pattern_predictor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pc, upd_pc;
  logic [2:0] read_history, upd_history;
  logic       read_hit, upd_valid, upd_taken, evict;
  logic       predict_taken, predict_valid, upd_ready, busy;

  always #5 clk = ~clk;

  branch_pattern_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .read_history  (read_history),
    .read_hit      (read_hit),
    .predict_taken (predict_taken),
    .predict_valid (predict_valid),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_history   (upd_history),
    .upd_taken     (upd_taken),
    .evict         (evict),
    .upd_ready     (upd_ready),
    .busy          (busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] m [16][8];
  logic [1:0] expq [$];
  logic [1:0] exp_v;

  function automatic logic [1:0] msat(input logic [1:0] c, input logic t);
    logic [1:0] r;
    r = c;
    if (t && c != 2'd3) r = c + 2'd1;
    if (!t && c != 2'd0) r = c - 2'd1;
    return r;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++)
      for (int h = 0; h < 8; h++) m[r][h] = 2'b01;
  endtask

  task automatic model_clear_row(input int r);
    for (int h = 0; h < 8; h++) m[r][h] = 2'b01;
  endtask

  // Drive read inputs and queue the expected {predict_valid, predict_taken}.
  task automatic set_read(input logic [9:0] p, input logic [2:0] h, input logic hit,
                          input logic blk);
    pc = p; read_history = h; read_hit = hit;
    expq.push_back((hit && !blk) ? {1'b1, m[p[3:0]][h][1]} : 2'b00);
  endtask

  // One accepted update (caller guarantees upd_ready); model trains on the accept edge.
  task automatic upd(input logic [9:0] p, input logic [2:0] h, input logic t, input logic ev);
    upd_valid = 1'b1; upd_pc = p; upd_history = h; upd_taken = t; evict = ev;
    @(posedge clk);
    if (!ev) m[p[3:0]][h] = msat(m[p[3:0]][h], t);
    #1;
    upd_valid = 1'b0; evict = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; read_hit = 1'b0; pc = '0; read_history = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_history = '0; upd_taken = 1'b0; evict = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({predict_valid, predict_taken, upd_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_outputs: got v/t/rdy/busy=%b required 0010",
               {predict_valid, predict_taken, upd_ready, busy});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_read(10'h015, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    exp_v = expq.pop_front(); checks++;
    if ({predict_valid, predict_taken} !== exp_v || exp_v !== 2'b10) begin
      errors++;
      $display("FAIL reset_read: got %b required %b", {predict_valid, predict_taken}, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    logic [1:0] got;
    upd(10'h015, 3'b000, 1'b1, 1'b0);
    upd(10'h015, 3'b000, 1'b1, 1'b0);
    set_read(10'h015, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL sat_two_taken: got %b required %b", got, exp_v);
    end
    @(posedge clk); #1;
    upd(10'h015, 3'b000, 1'b1, 1'b0);
    upd(10'h015, 3'b000, 1'b0, 1'b0);
    set_read(10'h015, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL sat_hold_11: got %b required %b", got, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    logic [1:0] got;
    upd(10'h015, 3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_read((i == 2) ? 10'h3C5 : 10'h005, (i == 2) ? 3'b011 : 3'b010, 1'b1, 1'b0);
      @(negedge clk);
      got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL forward_%0d: got %b required %b", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_evict();
    logic [1:0] got;
    for (int h = 0; h < 8; h++) begin
      upd(10'h017, 3'(h), 1'b1, 1'b0);
      upd(10'h017, 3'(h), 1'b1, 1'b0);
    end
    upd(10'h016, 3'b000, 1'b1, 1'b0);
    upd(10'h016, 3'b000, 1'b1, 1'b0);
    upd(10'h017, 3'b101, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      // A second evict held against a busy table must not queue another clear.
      upd_valid = (i >= 1 && i <= 5); evict = 1'b1; upd_pc = 10'h016;
      set_read((i % 2) ? 10'h016 : 10'h017, 3'(i), 1'b1, 1'b1);
      @(negedge clk);
      got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
      if ({got, busy, upd_ready} !== {exp_v, 2'b10}) begin
        errors++;
        $display("FAIL evict_busy_%0d: got v/t/busy/rdy=%b required %b", i,
                 {got, busy, upd_ready}, {exp_v, 2'b10});
      end
      @(posedge clk); #1;
    end
    upd_valid = 1'b0; evict = 1'b0;
    model_clear_row(7);
    for (int i = 0; i < 10; i++) begin
      set_read((i < 8) ? 10'h017 : 10'h216, (i < 8) ? 3'(i) : 3'b000, 1'b1, 1'b0);
      @(negedge clk);
      got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
      if ({got, busy, upd_ready} !== {exp_v, 2'b01}) begin
        errors++;
        $display("FAIL evict_after_%0d: got v/t/busy/rdy=%b required %b", i,
                 {got, busy, upd_ready}, {exp_v, 2'b01});
      end
      @(posedge clk); #1;
    end
    upd(10'h017, 3'b011, 1'b1, 1'b0);
    set_read(10'h017, 3'b011, 1'b1, 1'b0);
    @(negedge clk);
    got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL evict_clear_value: got %b required %b", got, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_update_during_clear();
    logic [1:0] got;
    upd(10'h012, 3'b001, 1'b1, 1'b0);
    upd(10'h019, 3'b000, 1'b0, 1'b1);
    model_clear_row(9);
    upd_valid = 1'b1; upd_pc = 10'h012; upd_history = 3'b001; upd_taken = 1'b0; evict = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (upd_ready !== 1'b0) begin
        errors++; $display("FAIL clear_block_%0d: got upd_ready=%b required 0", i, upd_ready);
      end
      @(posedge clk); #1;
    end
    @(posedge clk);
    m[2][1] = msat(m[2][1], 1'b0);
    #1;
    upd_valid = 1'b0;
    set_read(10'h012, 3'b001, 1'b1, 1'b0);
    @(negedge clk);
    got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL clear_replay_nt: got %b required %b", got, exp_v);
    end
    @(posedge clk); #1;
    upd(10'h012, 3'b001, 1'b1, 1'b0);
    set_read(10'h012, 3'b001, 1'b1, 1'b0);
    @(negedge clk);
    got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL clear_replay_one_step: got %b required %b", got, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_clear();
    logic [1:0] got;
    upd(10'h014, 3'b101, 1'b1, 1'b0);
    upd(10'h014, 3'b101, 1'b1, 1'b0);
    upd(10'h014, 3'b000, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL midclear_busy: got busy=%b required 1", busy);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, upd_ready} !== 2'b01) begin
      errors++; $display("FAIL midclear_reset: got busy/rdy=%b required 01", {busy, upd_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int r = 0; r < 16; r++) begin
      for (int h = 0; h < 8; h++) begin
        set_read({6'($urandom_range(0, 63)), 4'(r)}, 3'(h), 1'b1, 1'b0);
        @(negedge clk);
        got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
        if (got !== exp_v) begin
          errors++; $display("FAIL table_reset r%0d h%0d: got %b required %b", r, h, got, exp_v);
        end
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      set_read(10'($urandom_range(0, 1023)), 3'(i * 2), 1'b0, 1'b0);
      @(negedge clk);
      got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL no_hit_%0d: got %b required %b", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
    upd(10'h014, 3'b101, 1'b1, 1'b0);
    set_read(10'h014, 3'b101, 1'b1, 1'b0);
    @(negedge clk);
    got = {predict_valid, predict_taken}; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL reset_value_01: got %b required %b", got, exp_v);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_forward();
    test_evict();
    test_update_during_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
